// File: rtl/calc_pkg.sv
// Shared types and helpers for the history calculator: opcodes, display kinds,
// FSM state encoding and the display-hold cycle computation.
package calc_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        K_A    = 2'd0,
        K_B    = 2'd1,
        K_R    = 2'd2,
        K_HIST = 2'd3
    } kind_e;

    typedef enum logic [2:0] {
        CAP_A   = 3'd0,
        SHOW_A  = 3'd1,
        CAP_B   = 3'd2,
        SHOW_B  = 3'd3,
        WAIT_OP = 3'd4,
        SHOW_R  = 3'd5,
        BROWSE  = 3'd6
    } state_e;

    // 64-bit intermediate: 100 MHz times a one-second hold overflows 32 bits.
    function automatic int hold_cycles(input longint clk_hz, input longint show_ms);
        longint c;
        c = (clk_hz * show_ms) / 1000;
        if (c < 1) c = 1;
        return int'(c);
    endfunction

    // Lowest set pulse index wins when several ops arrive together.
    function automatic op_e pick_op(input logic [3:0] pulses);
        if (pulses[0]) return ADD;
        if (pulses[1]) return SUB;
        if (pulses[2]) return AND;
        return OR;
    endfunction

endpackage

// File: rtl/calc_hist_buf.sv
// Circular result history: DEPTH entries of W+1 bits, saturating count and an
// age-indexed combinational read port (age 0 = most recent write).
module calc_hist_buf
    import calc_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [W:0]                   wr_data,
    input  logic [$clog2(DEPTH)-1:0]     rd_age,
    output logic [W:0]                   rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + AW'(1);
            if (count != CW'(DEPTH)) begin
                count <= count + CW'(1);
            end
        end
    end

    // DEPTH is a power of two, so the AW-bit subtraction wraps modulo DEPTH.
    assign rd_addr = wr_ptr - AW'(1) - rd_age;
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/calc_hist_core.sv
// Calculator sequencer: capture/show A and B, wait for an op, show the result,
// log it into a circular history, and browse that history newest-first.
module calc_hist_core
    import calc_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 4,
    parameter int CLK_HZ  = 100_000_000,
    parameter int SHOW_MS = 1000
) (
    input  logic                         CLK100MHZ,
    input  logic                         RESET,
    input  logic [W-1:0]                 data_in,
    input  logic [3:0]                   op_pulse,
    input  logic                         browse_en,
    input  logic                         browse_step,
    output logic [W:0]                   disp_value,
    output logic [1:0]                   disp_kind,
    output logic [2:0]                   state_o,
    output logic                         flag_carry,
    output logic                         flag_neg,
    output logic                         result_valid,
    output logic [$clog2(DEPTH+1)-1:0]   hist_count,
    output logic [$clog2(DEPTH)-1:0]     hist_idx
);

    localparam int HOLD_CYC = hold_cycles(CLK_HZ, SHOW_MS);
    localparam int TMR_W    = $clog2(HOLD_CYC + 1);
    localparam int AW       = $clog2(DEPTH);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYC - 1);

    // Strobes: op_pulse and browse_step are single-cycle, acted on only in the
    // state that consumes them; result_valid is a one-cycle pulse with no
    // backpressure, coincident with the history write.
    state_e         state, state_nxt;
    kind_e          kind;
    logic [W-1:0]   a, b;
    logic [W:0]     r;
    logic [TMR_W-1:0] timer;
    logic           hold_done;
    logic           op_fire;
    op_e            op_sel;
    logic [W:0]     alu_res;
    logic           alu_c, alu_n;
    logic [W:0]     hist_rd;

    assign hold_done = (timer == HOLD_LAST);
    assign op_sel    = pick_op(op_pulse);
    assign op_fire   = (state == WAIT_OP) && (state_nxt == SHOW_R);

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_n   = 1'b0;
        case (op_sel)
            ADD: begin
                alu_res = {1'b0, a} + {1'b0, b};
                alu_c   = alu_res[W];
            end
            SUB: begin
                alu_res = {1'b0, a} - {1'b0, b};
                alu_n   = (a < b);
            end
            AND:     alu_res = {1'b0, a & b};
            OR:      alu_res = {1'b0, a | b};
            default: alu_res = '0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            state <= CAP_A;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state. Browse requests are held off during SHOW_R so a
    // result that has been logged is always displayed for its full hold.
    always_comb begin
        state_nxt = state;
        case (state)
            CAP_A:   state_nxt = SHOW_A;
            SHOW_A:  if (hold_done) state_nxt = CAP_B;
            CAP_B:   state_nxt = SHOW_B;
            SHOW_B:  if (hold_done) state_nxt = WAIT_OP;
            WAIT_OP: if (|op_pulse) state_nxt = SHOW_R;
            SHOW_R:  if (hold_done) state_nxt = browse_en ? BROWSE : CAP_A;
            BROWSE:  if (!browse_en) state_nxt = CAP_A;
            default: state_nxt = CAP_A;
        endcase
        if (browse_en && (state != SHOW_R) && (state != BROWSE)) begin
            state_nxt = BROWSE;
        end
    end

    // FSM: outputs
    always_comb begin
        disp_value = '0;
        kind       = K_A;
        case (state)
            CAP_A, SHOW_A: begin
                disp_value = {1'b0, a};
                kind       = K_A;
            end
            CAP_B, SHOW_B, WAIT_OP: begin
                disp_value = {1'b0, b};
                kind       = K_B;
            end
            SHOW_R: begin
                disp_value = r;
                kind       = K_R;
            end
            BROWSE: begin
                disp_value = (hist_count == '0) ? '0 : hist_rd;
                kind       = K_HIST;
            end
            default: begin
                disp_value = '0;
                kind       = K_A;
            end
        endcase
    end

    assign disp_kind = kind;
    assign state_o   = state;

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            a            <= '0;
            b            <= '0;
            r            <= '0;
            flag_carry   <= 1'b0;
            flag_neg     <= 1'b0;
            result_valid <= 1'b0;
            timer        <= '0;
            hist_idx     <= '0;
        end else begin
            result_valid <= op_fire;

            // Timer restarts on every state change and parks at its last value.
            if (state_nxt != state) begin
                timer <= '0;
            end else if (!hold_done) begin
                timer <= timer + TMR_W'(1);
            end

            if (state == CAP_A) a <= data_in;
            if (state == CAP_B) b <= data_in;

            if (op_fire) begin
                r          <= alu_res;
                flag_carry <= alu_c;
                flag_neg   <= alu_n;
            end

            if ((state_nxt == BROWSE) && (state != BROWSE)) begin
                hist_idx <= '0;
            end else if ((state == BROWSE) && browse_en && browse_step) begin
                if ((hist_count == '0) || (CW'(hist_idx) == hist_count - CW'(1))) begin
                    hist_idx <= '0;
                end else begin
                    hist_idx <= hist_idx + AW'(1);
                end
            end
        end
    end

    calc_hist_buf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk     (CLK100MHZ),
        .rst     (RESET),
        .wr_en   (op_fire),
        .wr_data (alu_res),
        .rd_age  (hist_idx),
        .rd_data (hist_rd),
        .count   (hist_count)
    );

endmodule

// File: tb/tb_calc_hist_core.sv
// Bench for calc_hist_core: directed sessions with literal expectations plus a
// negedge compare process backed by a result/history model.
module tb_calc_hist_core;

    localparam int HOLD  = 10;
    localparam int DEPTH = 4;
    localparam logic [2:0] S_CAP_A   = 3'd0;
    localparam logic [2:0] S_SHOW_A  = 3'd1;
    localparam logic [2:0] S_CAP_B   = 3'd2;
    localparam logic [2:0] S_SHOW_B  = 3'd3;
    localparam logic [2:0] S_WAIT_OP = 3'd4;
    localparam logic [2:0] S_SHOW_R  = 3'd5;
    localparam logic [2:0] S_BROWSE  = 3'd6;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] data_in;
    logic [3:0] op_pulse;
    logic       browse_en;
    logic       browse_step;
    logic [8:0] disp_value;
    logic [1:0] disp_kind;
    logic [2:0] state_o;
    logic       flag_carry;
    logic       flag_neg;
    logic       result_valid;
    logic [2:0] hist_count;
    logic [1:0] hist_idx;

    int checks = 0;
    int errors = 0;

    calc_hist_core #(
        .W       (8),
        .DEPTH   (DEPTH),
        .CLK_HZ  (1000),
        .SHOW_MS (10)
    ) dut (
        .CLK100MHZ    (clk),
        .RESET        (RESET),
        .data_in      (data_in),
        .op_pulse     (op_pulse),
        .browse_en    (browse_en),
        .browse_step  (browse_step),
        .disp_value   (disp_value),
        .disp_kind    (disp_kind),
        .state_o      (state_o),
        .flag_carry   (flag_carry),
        .flag_neg     (flag_neg),
        .result_valid (result_valid),
        .hist_count   (hist_count),
        .hist_idx     (hist_idx)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: result of an op from the arithmetic rules, packed as {carry, neg, r}
    function automatic logic [10:0] model_op(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] ops);
        int ia, ib, res;
        logic c, n;
        ia = a; ib = b; c = 1'b0; n = 1'b0;
        if (ops[0]) begin
            res = ia + ib;
            c   = (res >= 256);
        end else if (ops[1]) begin
            res = (ia - ib) & 32'h1FF;
            n   = (ia < ib);
        end else if (ops[2]) begin
            res = ia & ib;
        end else begin
            res = ia | ib;
        end
        return {c, n, res[8:0]};
    endfunction

    // scoreboard state
    logic [8:0] exp_q[$];
    logic [8:0] hist_q[$];
    logic       exp_c, exp_n, mc, mn;
    logic [7:0] cap_a, cap_b;
    logic [8:0] last_r;
    logic [2:0] prev_st, st;
    logic       prev_ben, op_pend, step_pend;
    int         run_len, exp_idx;

    always @(negedge clk) begin
        if (RESET) begin
            exp_q.delete();
            hist_q.delete();
            mc = 1'b0; mn = 1'b0; op_pend = 1'b0; step_pend = 1'b0;
            prev_st = S_CAP_A; prev_ben = 1'b0; run_len = 0; exp_idx = 0;
        end else begin
            st = state_o;
            if (op_pend) begin
                op_pend = 1'b0;
                chk("rv_pulse", result_valid, 1);
                chk("r_state", st, S_SHOW_R);
                last_r = exp_q.pop_front();
                mc = exp_c; mn = exp_n;
                hist_q.push_front(last_r);
                if (hist_q.size() > DEPTH) void'(hist_q.pop_back());
            end else begin
                chk("rv_idle", result_valid, 0);
            end
            chk("hist_count", hist_count, hist_q.size());
            chk("flag_carry", flag_carry, mc);
            chk("flag_neg", flag_neg, mn);

            if (st != prev_st) begin
                case (prev_st)
                    S_SHOW_A, S_SHOW_B: begin
                        if (prev_ben) chk("show_to_browse", st, S_BROWSE);
                        else begin
                            chk("show_len", run_len, HOLD);
                            chk("show_next", st, (prev_st == S_SHOW_A) ? S_CAP_B : S_WAIT_OP);
                        end
                    end
                    S_SHOW_R: begin
                        chk("show_r_len", run_len, HOLD);
                        chk("show_r_next", st, prev_ben ? S_BROWSE : S_CAP_A);
                    end
                    S_BROWSE: chk("browse_exit", st, S_CAP_A);
                    default: ;
                endcase
                run_len = 1;
            end else begin
                run_len++;
            end

            case (st)
                S_SHOW_A: begin
                    chk("disp_a", disp_value, {1'b0, cap_a});
                    chk("kind_a", disp_kind, 0);
                end
                S_SHOW_B, S_WAIT_OP: begin
                    chk("disp_b", disp_value, {1'b0, cap_b});
                    chk("kind_b", disp_kind, 1);
                end
                S_SHOW_R: begin
                    chk("disp_r", disp_value, last_r);
                    chk("kind_r", disp_kind, 2);
                end
                S_BROWSE: begin
                    if (prev_st != S_BROWSE) exp_idx = 0;
                    else if (step_pend) begin
                        if (hist_q.size() == 0 || exp_idx == hist_q.size() - 1) exp_idx = 0;
                        else exp_idx++;
                    end
                    chk("browse_idx", hist_idx, exp_idx);
                    chk("browse_disp", disp_value, (hist_q.size() == 0) ? 9'd0 : hist_q[exp_idx]);
                    chk("kind_hist", disp_kind, 3);
                end
                default: ;
            endcase

            if (st == S_CAP_A) cap_a = data_in;
            if (st == S_CAP_B) cap_b = data_in;
            if (st == S_WAIT_OP && op_pulse != 4'b0 && !browse_en) begin
                {exp_c, exp_n, last_r} = model_op(cap_a, cap_b, op_pulse);
                exp_q.push_back(last_r);
                op_pend = 1'b1;
            end
            step_pend = (st == S_BROWSE) && browse_en && browse_step;
            prev_ben  = browse_en;
            prev_st   = st;
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state_o !== s && n < budget) begin
            tick(1);
            n++;
        end
        chk("wait_state", state_o, s);
    endtask

    task automatic do_calc(input logic [7:0] a, input logic [7:0] b, input logic [3:0] ops,
                           input logic [3:0] junk, input logic [8:0] exp_r,
                           input logic exp_cy, input logic exp_ng);
        data_in = a;
        wait_state(S_CAP_A, 40);
        wait_state(S_SHOW_A, 4);
        data_in = b;
        if (junk != 4'b0) begin
            op_pulse = junk;
            tick(1);
            op_pulse = 4'b0;
            chk("junk_op_ignored", state_o, S_SHOW_A);
        end
        wait_state(S_WAIT_OP, 40);
        op_pulse = ops;
        tick(1);
        op_pulse = 4'b0;
        chk("lit_state_r", state_o, S_SHOW_R);
        chk("lit_rv", result_valid, 1);
        chk("lit_result", disp_value, exp_r);
        chk("lit_carry", flag_carry, exp_cy);
        chk("lit_neg", flag_neg, exp_ng);
    endtask

    logic [8:0] bv [4];
    logic [1:0] bi [4];

    initial begin
        RESET = 1'b1; data_in = 8'd0; op_pulse = 4'b0; browse_en = 1'b0; browse_step = 1'b0;
        tick(3);
        chk("rst_state", state_o, S_CAP_A);
        chk("rst_disp", disp_value, 0);
        chk("rst_count", hist_count, 0);
        chk("rst_flags", {flag_carry, flag_neg, result_valid}, 0);
        RESET = 1'b0;

        // 200 + 100 = 300 with carry; SHOW_R held exactly 10 cycles
        do_calc(8'd200, 8'd100, 4'b0001, 4'b0, 9'h12C, 1'b1, 1'b0);
        chk("lit_count1", hist_count, 1);
        tick(1);
        chk("lit_rv_drop", result_valid, 0);
        tick(8);
        chk("lit_hold_last", state_o, S_SHOW_R);
        tick(1);
        chk("lit_hold_exit", state_o, S_CAP_A);

        // abort in the middle of SHOW_A
        data_in = 8'd7;
        wait_state(S_SHOW_A, 4);
        tick(3);
        RESET = 1'b1;
        tick(1);
        chk("mid_rst_state", state_o, S_CAP_A);
        chk("mid_rst_disp", disp_value, 0);
        chk("mid_rst_count", hist_count, 0);
        chk("mid_rst_flags", {flag_carry, flag_neg}, 0);
        RESET = 1'b0;

        // priority, subtraction, ignored op in SHOW_A, then fill and overflow history
        do_calc(8'd5, 8'd9, 4'b0011, 4'b0, 9'h00E, 1'b0, 1'b0);
        do_calc(8'd5, 8'd9, 4'b0010, 4'b0010, 9'h1FC, 1'b0, 1'b1);
        do_calc(8'hF0, 8'h3C, 4'b0100, 4'b0, 9'h030, 1'b0, 1'b0);
        do_calc(8'h0F, 8'hA0, 4'b1000, 4'b0, 9'h0AF, 1'b0, 1'b0);
        do_calc(8'hFF, 8'hFF, 4'b1001, 4'b0, 9'h1FE, 1'b1, 1'b0);
        chk("lit_count_full", hist_count, 4);

        // browse request during SHOW_R waits for the hold to finish
        browse_en = 1'b1;
        tick(9);
        chk("lit_defer", state_o, S_SHOW_R);
        tick(1);
        chk("lit_browse", state_o, S_BROWSE);
        chk("lit_b0_idx", hist_idx, 0);
        chk("lit_b0_val", disp_value, 9'h1FE);
        bv[0] = 9'h0AF; bv[1] = 9'h030; bv[2] = 9'h1FC; bv[3] = 9'h1FE;
        bi[0] = 2'd1;   bi[1] = 2'd2;   bi[2] = 2'd3;   bi[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            browse_step = 1'b1;
            tick(1);
            browse_step = 1'b0;
            chk("lit_step_idx", hist_idx, bi[i]);
            chk("lit_step_val", disp_value, bv[i]);
            tick(1);
        end
        browse_en = 1'b0;
        tick(1);
        chk("lit_browse_off", state_o, S_CAP_A);

        // browse over an empty history
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        browse_en = 1'b1;
        tick(1);
        chk("lit_empty_state", state_o, S_BROWSE);
        chk("lit_empty_val", disp_value, 0);
        chk("lit_empty_idx", hist_idx, 0);
        browse_step = 1'b1;
        tick(1);
        browse_step = 1'b0;
        chk("lit_empty_step_idx", hist_idx, 0);
        chk("lit_empty_step_val", disp_value, 0);
        browse_en = 1'b0;
        tick(1);
        chk("lit_empty_exit", state_o, S_CAP_A);
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
